sram_data_port: RTL and testbench

//  Memory-side responder for the CPU MM-stage data interface (address/data_i/rd/wr/access_sz).

---
 rtl/sram_data_port.sv | 182 ++++++++++++++++++
 tb/tb_sram_data_port.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_data_port.sv
// Single-request data-memory responder: turns MM-stage loads/stores into timed async-SRAM cycles.
// Optional DMEM_ADDR_CHECK_EN: reject misaligned/out-of-range requests with a fault pulse, no SRAM cycle.
module sram_data_port #(
    parameter int ADDR_W      = 20,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       address,
    input  logic [31:0]       data_i,
    input  logic              rd,
    input  logic              wr,
    input  logic [1:0]        access_sz,
    output logic [31:0]       data_o,
    output logic              ready,
    output logic              fault,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n
);
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        lane_q, lane_d;
    logic [1:0]        sz_q, sz_d;
    logic              wr_q, wr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [3:0]        wait_q, wait_d;
    logic [31:0]       rdata_q, rdata_d;

    // Request decode: lane offset is forced to the natural alignment of the access size.
    logic [1:0]  req_lane;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [31:0] rd_shift;
    logic [31:0] rd_lane;

    always_comb begin
        req_lane  = 2'b00;
        req_be    = 4'h0;
        req_wdata = data_i;
        if (access_sz == SZ_BYTE) begin
            req_lane  = address[1:0];
            req_be    = ~(4'b0001 << address[1:0]);
            req_wdata = {4{data_i[7:0]}};
        end else if (access_sz == SZ_HALF) begin
            req_lane  = {address[1], 1'b0};
            req_be    = address[1] ? 4'h3 : 4'hC;
            req_wdata = {2{data_i[15:0]}};
        end
    end

    always_comb begin
        rd_shift = sram_rdata >> {lane_q, 3'b000};
        if (sz_q == SZ_BYTE)      rd_lane = {24'h0, rd_shift[7:0]};
        else if (sz_q == SZ_HALF) rd_lane = {16'h0, rd_shift[15:0]};
        else                      rd_lane = sram_rdata;
    end

`ifdef DMEM_ADDR_CHECK_EN
    logic fault_q, fault_d;
    logic req_bad;

    always_comb begin
        req_bad = ((address >> (ADDR_W + 2)) != 32'h0);
        if (access_sz == SZ_HALF && address[0])                    req_bad = 1'b1;
        if (access_sz != SZ_BYTE && access_sz != SZ_HALF && address[1:0] != 2'b00) req_bad = 1'b1;
    end
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^address[31:ADDR_W+2];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            lane_q  <= 2'b00;
            sz_q    <= 2'b00;
            wr_q    <= 1'b0;
            wdata_q <= 32'h0;
            be_q    <= 4'hF;
            wait_q  <= 4'h0;
            rdata_q <= 32'h0;
`ifdef DMEM_ADDR_CHECK_EN
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            lane_q  <= lane_d;
            sz_q    <= sz_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            wait_q  <= wait_d;
            rdata_q <= rdata_d;
`ifdef DMEM_ADDR_CHECK_EN
            fault_q <= fault_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        lane_d  = lane_q;
        sz_d    = sz_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        wait_d  = wait_q;
        rdata_d = rdata_q;
`ifdef DMEM_ADDR_CHECK_EN
        fault_d = fault_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (rd || wr) begin
                    addr_d  = address[ADDR_W+1:2];
                    lane_d  = req_lane;
                    sz_d    = access_sz;
                    wr_d    = wr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    rdata_d = 32'h0;
                    state_d = S_SETUP;
`ifdef DMEM_ADDR_CHECK_EN
                    fault_d = req_bad;
                    if (req_bad) begin
                        be_d    = 4'hF;
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_SETUP: begin
                wait_d  = 4'h0;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (wait_q == WAIT_LAST) begin
                    if (!wr_q) rdata_d = rd_lane;
                    state_d = S_DONE;
                end else begin
                    wait_d = wait_q + 4'h1;
                end
            end
            default: begin
                be_d    = 4'hF;
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobes are a pure decode of the registered state, so reset deasserts them at the same edge.
    always_comb begin
        sram_ce_n  = !(state_q == S_SETUP || state_q == S_ACCESS);
        sram_oe_n  = !(state_q == S_ACCESS && !wr_q);
        sram_we_n  = !(state_q == S_ACCESS && wr_q);
        sram_be_n  = be_q;
        sram_addr  = addr_q;
        sram_wdata = wdata_q;
        ready      = (state_q == S_DONE);
        data_o     = rdata_q;
`ifdef DMEM_ADDR_CHECK_EN
        fault      = (state_q == S_DONE) && fault_q;
`else
        fault      = 1'b0;
`endif
    end
endmodule

// File: tb/tb_sram_data_port.sv
// Directed bench for sram_data_port with a small behavioural SRAM (WAIT_STATES=1).
module tb_sram_data_port;
    localparam int AW = 20;
    localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   address, data_i, data_o, sram_wdata, sram_rdata;
    logic          rd, wr, ready, fault;
    logic [1:0]    access_sz;
    logic [AW-1:0] sram_addr;
    logic          sram_ce_n, sram_oe_n, sram_we_n;
    logic [3:0]    sram_be_n;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] mem [16];

    always #5 clk = ~clk;

    sram_data_port #(.ADDR_W(AW), .WAIT_STATES(1)) dut (
        .clk(clk), .rst_n(rst_n), .address(address), .data_i(data_i), .rd(rd), .wr(wr),
        .access_sz(access_sz), .data_o(data_o), .ready(ready), .fault(fault),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
    );

    assign sram_rdata = mem[sram_addr[3:0]];

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n)
            for (int k = 0; k < 4; k++)
                if (!sram_be_n[k]) mem[sram_addr[3:0]][k*8 +: 8] <= sram_wdata[k*8 +: 8];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Result of the last transaction, observed at negedges.
    int          lat, ce_cnt, oe_cnt, we_cnt;
    logic [3:0]  obs_be;
    logic [31:0] obs_wd, obs_q;
    logic [AW-1:0] obs_addr;
    logic        obs_flt;

    // Request must already be driven; counts edges from the sampling edge up to the ready cycle.
    task automatic wait_done(input string tag);
        bit done = 0;
        lat = 0; ce_cnt = 0; oe_cnt = 0; we_cnt = 0;
        obs_be = 4'hx; obs_wd = 'x; obs_q = 'x; obs_addr = 'x; obs_flt = 1'bx;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (!sram_ce_n) begin
                ce_cnt++;
                obs_be = sram_be_n; obs_wd = sram_wdata; obs_addr = sram_addr;
            end
            if (!sram_oe_n) oe_cnt++;
            if (!sram_we_n) we_cnt++;
            if (ready) begin
                obs_q = data_o; obs_flt = fault; done = 1;
            end
        end
        rd = 0; wr = 0;
        if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic xfer(input string tag, input bit w, input logic [31:0] a,
                        input logic [1:0] sz, input logic [31:0] d);
        @(negedge clk);
        wr = w; rd = !w; address = a; access_sz = sz; data_i = d;
        wait_done(tag);
    endtask

    int rdy_cnt, rdy_at1, rdy_at2, ce_at;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        rst_n = 0; rd = 0; wr = 1; address = 32'h20; access_sz = SZ_W; data_i = 32'h0;

        // Reset held two cycles with a pending write
        repeat (2) begin
            @(negedge clk);
            check("rst_strobes", {25'h0, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n}, 32'h7F);
            check("rst_ready", {31'h0, ready}, 32'h0);
        end
        check("rst_data_o", data_o, 32'h0);
        check("rst_sram_addr", {12'h0, sram_addr}, 32'h0);
        check("rst_wdata", sram_wdata, 32'h0);
        check("rst_fault", {31'h0, fault}, 32'h0);
        rst_n = 1;
        wait_done("rel");
        check("rel_latency", lat, 32'd4);

        // Word store then load
        xfer("wst", 1, 32'h10, SZ_W, 32'hDEADBEEF);
        check("wst_latency", lat, 32'd4);
        check("wst_we_cycles", we_cnt, 32'd2);
        check("wst_oe_cycles", oe_cnt, 32'd0);
        check("wst_be", {28'h0, obs_be}, 32'h0);
        check("wst_addr", {12'h0, obs_addr}, 32'h4);
        check("wst_wdata", obs_wd, 32'hDEADBEEF);
        xfer("wld", 0, 32'h10, SZ_W, 32'h0);
        check("wld_latency", lat, 32'd4);
        check("wld_oe_cycles", oe_cnt, 32'd2);
        check("wld_data", obs_q, 32'hDEADBEEF);
        check("wld_fault", {31'h0, obs_flt}, 32'h0);

        // Byte store / load at lane 3
        xfer("bst", 1, 32'h13, SZ_B, 32'h000000A5);
        check("bst_be", {28'h0, obs_be}, 32'h7);
        check("bst_wdata", obs_wd, 32'hA5A5A5A5);
        check("bst_mem", mem[4], 32'hA5ADBEEF);
        xfer("bld", 0, 32'h13, SZ_B, 32'h0);
        check("bld_data", obs_q, 32'h000000A5);
        xfer("bld1", 0, 32'h11, SZ_B, 32'h0);
        check("bld1_be", {28'h0, obs_be}, 32'hD);
        check("bld1_data", obs_q, 32'h000000BE);

        // Half load from upper half; half store replication and forced alignment
        xfer("w2", 1, 32'h10, SZ_W, 32'h12345678);
        xfer("hld", 0, 32'h12, SZ_H, 32'h0);
        check("hld_be", {28'h0, obs_be}, 32'h3);
        check("hld_data", obs_q, 32'h00001234);
        xfer("hst", 1, 32'h11, SZ_H, 32'hFFFFCAFE);
        check("hst_be", {28'h0, obs_be}, 32'hC);
        check("hst_wdata", obs_wd, 32'hCAFECAFE);
        check("hst_mem", mem[4], 32'h1234CAFE);
`ifndef DMEM_ADDR_CHECK_EN
        xfer("whi", 0, 32'h8000_0013, SZ_W, 32'h0);
        check("whi_be", {28'h0, obs_be}, 32'h0);
        check("whi_data", obs_q, 32'h1234CAFE);
        check("whi_fault", {31'h0, obs_flt}, 32'h0);
`endif

        // Back-to-back: rd held through DONE
        rdy_cnt = 0; rdy_at1 = 0; rdy_at2 = 0; ce_at = 0;
        @(negedge clk);
        rd = 1; wr = 0; address = 32'h10; access_sz = SZ_W;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (!sram_ce_n && rdy_cnt == 1 && ce_at == 0) ce_at = i;
            if (ready) begin
                rdy_cnt++;
                if (rdy_cnt == 1) rdy_at1 = i;
                if (rdy_cnt == 2) begin rdy_at2 = i; rd = 0; end
            end
        end
        check("b2b_pulses", rdy_cnt, 32'd2);
        check("b2b_first", rdy_at1, 32'd4);
        check("b2b_second_setup", ce_at, 32'd6);
        check("b2b_second", rdy_at2, 32'd9);

        // Reset during ACCESS aborts the store
        @(negedge clk);
        wr = 1; address = 32'h30; access_sz = SZ_W; data_i = 32'h11111111;
        for (int i = 0; i < 10 && sram_we_n; i++) @(negedge clk);
        check("abt_in_access", {31'h0, sram_we_n}, 32'h0);
        rst_n = 0; wr = 0;
        @(negedge clk);
        check("abt_strobes", {25'h0, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n}, 32'h7F);
        check("abt_ready", {31'h0, ready}, 32'h0);
        rst_n = 1;
        rdy_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (ready) rdy_cnt++;
        end
        check("abt_no_ready", rdy_cnt, 32'd0);

`ifdef DMEM_ADDR_CHECK_EN
        xfer("flt_mis", 0, 32'h2, SZ_W, 32'h0);
        check("flt_latency", lat, 32'd1);
        check("flt_fault", {31'h0, obs_flt}, 32'h1);
        check("flt_data", obs_q, 32'h0);
        check("flt_ce", ce_cnt, 32'd0);
        xfer("flt_hi", 1, 32'h0040_0000, SZ_B, 32'h0);
        check("flt_hi_fault", {31'h0, obs_flt}, 32'h1);
        check("flt_hi_ce", ce_cnt, 32'd0);
        xfer("ok", 0, 32'h12, SZ_H, 32'h0);
        check("ok_fault", {31'h0, obs_flt}, 32'h0);
        check("ok_data", obs_q, 32'h00001234);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
